// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage, decode control and the instruction ROM.
// The master side is the fetch stage. The slave side is decode plus the memory.
interface if_stage_if #(
  parameter int AW = 12
);
  logic          stall;
  logic          flush;
  logic          redirect;
  logic [31:0]   npc;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_rdata;
  logic [31:0]   F_pc;
  logic [31:0]   D_instr;
  logic [31:0]   D_pc;
  logic [31:0]   D_pc8;
  logic          D_valid;
  logic          D_exc_adel;
  logic [31:0]   fetch_count;

  modport master (
    input  stall, flush, redirect, npc, im_rdata,
    output im_addr, F_pc, D_instr, D_pc, D_pc8, D_valid, D_exc_adel, fetch_count
  );

  modport slave (
    output stall, flush, redirect, npc, im_rdata,
    input  im_addr, F_pc, D_instr, D_pc, D_pc8, D_valid, D_exc_adel, fetch_count
  );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage. It holds the PC and the IF/ID register and checks fetch addresses.
// Redirects use one architectural delay slot.
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  if_stage_if.master  bus
);
  localparam int AW = $clog2(IM_WORDS);
  // Widened to 33 bits so a ROM window ending at 2^32 does not wrap to zero.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(IM_WORDS) * 33'd4;

  logic [31:0] pc_q, pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic [31:0] d_pc8_q, d_pc8_d;
  logic        d_valid_q, d_valid_d;
  logic        d_adel_q, d_adel_d;
  logic [31:0] cnt_q, cnt_d;
  logic        adel;

  always_comb begin
    adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || ({1'b0, pc_q} >= IM_END);
  end

  assign bus.im_addr     = AW'((pc_q - IM_BASE) >> 2);
  assign bus.F_pc        = pc_q;
  assign bus.D_instr     = d_instr_q;
  assign bus.D_pc        = d_pc_q;
  assign bus.D_pc8       = d_pc8_q;
  assign bus.D_valid     = d_valid_q;
  assign bus.D_exc_adel  = d_adel_q;
  assign bus.fetch_count = cnt_q;

  always_comb begin
    // NOTE: every next-state value defaults to hold first, so no path can infer a latch.
    pc_d      = pc_q;
    d_instr_d = d_instr_q;
    d_pc_d    = d_pc_q;
    d_pc8_d   = d_pc8_q;
    d_valid_d = d_valid_q;
    d_adel_d  = d_adel_q;
    cnt_d     = cnt_q;

    // A stall also drops any pending redirect. Decode re-asserts it once the stall clears.
    if (!bus.stall) begin
      pc_d = bus.redirect ? bus.npc : pc_q + 32'd4;
    end

    if (bus.flush) begin
      d_instr_d = '0;
      d_valid_d = 1'b0;
      d_adel_d  = 1'b0;
    end else if (!bus.stall) begin
      d_instr_d = adel ? 32'h0 : bus.im_rdata;
      d_pc_d    = pc_q;
      d_pc8_d   = pc_q + 32'd8;
      d_valid_d = 1'b1;
      d_adel_d  = adel;
      cnt_d     = cnt_q + 32'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Reset is asynchronous and reaches every flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= PC_RESET;
      d_instr_q <= '0;
      d_pc_q    <= '0;
      d_pc8_q   <= '0;
      d_valid_q <= 1'b0;
      d_adel_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      d_instr_q <= d_instr_d;
      d_pc_q    <= d_pc_d;
      d_pc8_q   <= d_pc8_d;
      d_valid_q <= d_valid_d;
      d_adel_q  <= d_adel_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage. It runs directed scenarios and then random traffic
// against a behavioural pipeline model.
module tb_if_stage;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam int          IM_WORDS = 4096;
  localparam int          AW       = $clog2(IM_WORDS);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  logic [31:0] rom [IM_WORDS];

  if_stage_if #(.AW(AW)) bus ();

  if_stage #(.PC_RESET(PC_RESET), .IM_BASE(IM_BASE), .IM_WORDS(IM_WORDS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  assign bus.im_rdata = rom[bus.im_addr];

  // The model state is updated once per clock edge from the architectural rules.
  logic [31:0] m_pc, m_instr, m_dpc, m_dpc8, m_cnt;
  logic        m_valid, m_adel;

  function automatic bit m_adel_of(input logic [31:0] p);
    longint a;
    a = longint'({32'd0, p});
    return (p % 4 != 0) || (a < longint'({32'd0, IM_BASE})) ||
           (a >= longint'({32'd0, IM_BASE}) + 4 * IM_WORDS);
  endfunction

  function automatic int m_index(input logic [31:0] p);
    return int'(((p - IM_BASE) / 4) % IM_WORDS);
  endfunction

  task automatic tick(input bit s, input bit f, input bit r, input logic [31:0] n);
    bus.stall = s; bus.flush = f; bus.redirect = r; bus.npc = n;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit random_rom);
    for (int k = 0; k < IM_WORDS; k++) rom[k] = random_rom ? $urandom : 32'(k + 1);
    bus.stall = 0; bus.flush = 0; bus.redirect = 0; bus.npc = 0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(0);
    reset_n = 1'b0;
    #1;
    n_total++; if (bus.F_pc !== 32'h3000) $display("FAIL reset_pc got %h want 00003000", bus.F_pc); else n_pass++;
    n_total++; if ({bus.D_instr, bus.D_pc, bus.D_pc8} !== 96'h0) $display("FAIL reset_d got %h %h %h want 0", bus.D_instr, bus.D_pc, bus.D_pc8); else n_pass++;
    n_total++; if ({bus.D_valid, bus.D_exc_adel} !== 2'b00) $display("FAIL reset_flags got %b%b want 00", bus.D_valid, bus.D_exc_adel); else n_pass++;
    n_total++; if (bus.fetch_count !== 32'h0) $display("FAIL reset_cnt got %0d want 0", bus.fetch_count); else n_pass++;
    n_total++; if (bus.im_addr !== '0) $display("FAIL reset_imaddr got %h want 0", bus.im_addr); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_sequential();
    do_reset(0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0);
      n_total++; if (bus.D_pc !== 32'h3000 + 32'(4 * i)) $display("FAIL seq_dpc%0d got %h want %h", i, bus.D_pc, 32'h3000 + 32'(4 * i)); else n_pass++;
      n_total++; if (bus.D_instr !== 32'(i + 1)) $display("FAIL seq_instr%0d got %h want %h", i, bus.D_instr, i + 1); else n_pass++;
      n_total++; if (bus.D_pc8 !== 32'h3008 + 32'(4 * i)) $display("FAIL seq_dpc8_%0d got %h want %h", i, bus.D_pc8, 32'h3008 + 32'(4 * i)); else n_pass++;
    end
    n_total++; if (bus.fetch_count !== 32'd3) $display("FAIL seq_cnt got %0d want 3", bus.fetch_count); else n_pass++;
    n_total++; if (bus.D_valid !== 1'b1) $display("FAIL seq_valid got %b want 1", bus.D_valid); else n_pass++;
  endtask

  task automatic test_redirect();
    do_reset(0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 32'h3020);
    n_total++; if (bus.D_pc !== 32'h3008 || bus.D_instr !== 32'd3) $display("FAIL redir_slot got %h/%h want 00003008/00000003", bus.D_pc, bus.D_instr); else n_pass++;
    n_total++; if (bus.F_pc !== 32'h3020) $display("FAIL redir_fpc got %h want 00003020", bus.F_pc); else n_pass++;
    tick(0, 0, 0, 0);
    n_total++; if (bus.D_pc !== 32'h3020 || bus.D_instr !== 32'd9 || bus.D_valid !== 1'b1) $display("FAIL redir_target got %h/%h/%b want 00003020/00000009/1", bus.D_pc, bus.D_instr, bus.D_valid); else n_pass++;
  endtask

  task automatic test_stall();
    do_reset(0);
    repeat (3) tick(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick(1, 0, 1, 32'h3040);
      n_total++; if (bus.F_pc !== 32'h300C) $display("FAIL stall_fpc%0d got %h want 0000300c", i, bus.F_pc); else n_pass++;
      n_total++; if (bus.D_pc !== 32'h3008 || bus.D_instr !== 32'd3) $display("FAIL stall_d%0d got %h/%h want 00003008/00000003", i, bus.D_pc, bus.D_instr); else n_pass++;
      n_total++; if (bus.fetch_count !== 32'd3) $display("FAIL stall_cnt%0d got %0d want 3", i, bus.fetch_count); else n_pass++;
    end
    tick(0, 0, 1, 32'h3040);
    n_total++; if (bus.F_pc !== 32'h3040) $display("FAIL stall_release_fpc got %h want 00003040", bus.F_pc); else n_pass++;
    n_total++; if (bus.D_pc !== 32'h300C || bus.fetch_count !== 32'd4) $display("FAIL stall_release_d got %h/%0d want 0000300c/4", bus.D_pc, bus.fetch_count); else n_pass++;
  endtask

  task automatic test_flush_and_adel();
    do_reset(0);
    repeat (5) tick(0, 0, 0, 0);
    tick(1, 1, 0, 0);
    n_total++; if (bus.D_valid !== 1'b0 || bus.D_instr !== 32'h0) $display("FAIL flush_bubble got %b/%h want 0/00000000", bus.D_valid, bus.D_instr); else n_pass++;
    n_total++; if (bus.F_pc !== 32'h3014 || bus.fetch_count !== 32'd5) $display("FAIL flush_hold got %h/%0d want 00003014/5", bus.F_pc, bus.fetch_count); else n_pass++;
    n_total++; if (bus.D_pc !== 32'h3010 || bus.D_pc8 !== 32'h3018) $display("FAIL flush_dpc got %h/%h want 00003010/00003018", bus.D_pc, bus.D_pc8); else n_pass++;
    tick(0, 0, 1, 32'h3002);
    tick(0, 0, 0, 0);
    n_total++; if ({bus.D_exc_adel, bus.D_valid} !== 2'b11 || bus.D_instr !== 32'h0 || bus.D_pc !== 32'h3002) $display("FAIL adel_misalign got %b%b/%h/%h want 11/0/00003002", bus.D_exc_adel, bus.D_valid, bus.D_instr, bus.D_pc); else n_pass++;
    n_total++; if (bus.fetch_count !== 32'd7) $display("FAIL adel_cnt got %0d want 7", bus.fetch_count); else n_pass++;
    tick(0, 0, 1, 32'h2FFC);
    tick(0, 0, 0, 0);
    n_total++; if ({bus.D_exc_adel, bus.D_valid} !== 2'b11 || bus.D_instr !== 32'h0 || bus.D_pc !== 32'h2FFC) $display("FAIL adel_below got %b%b/%h/%h want 11/0/00002ffc", bus.D_exc_adel, bus.D_valid, bus.D_instr, bus.D_pc); else n_pass++;
    n_total++; if (bus.fetch_count !== 32'd9) $display("FAIL adel_cnt2 got %0d want 9", bus.fetch_count); else n_pass++;
    tick(0, 0, 1, 32'h6FFC);
    tick(0, 0, 0, 0);
    n_total++; if (bus.D_exc_adel !== 1'b0 || bus.D_instr !== 32'd4096) $display("FAIL adel_top_ok got %b/%h want 0/00001000", bus.D_exc_adel, bus.D_instr); else n_pass++;
    n_total++; if (bus.F_pc !== 32'h7000 || bus.im_addr !== '0) $display("FAIL adel_trunc got %h/%h want 00007000/000", bus.F_pc, bus.im_addr); else n_pass++;
    tick(0, 0, 0, 0);
    n_total++; if (bus.D_exc_adel !== 1'b1 || bus.D_instr !== 32'h0) $display("FAIL adel_above got %b/%h want 1/0", bus.D_exc_adel, bus.D_instr); else n_pass++;
    tick(0, 0, 1, 32'hFFFF_FFFC);
    tick(0, 0, 0, 0);
    n_total++; if (bus.F_pc !== 32'h0 || bus.D_pc8 !== 32'h4) $display("FAIL wrap_pc got %h/%h want 00000000/00000004", bus.F_pc, bus.D_pc8); else n_pass++;
    tick(0, 0, 0, 0);
    n_total++; if (bus.D_exc_adel !== 1'b1 || bus.D_pc !== 32'h0 || bus.D_pc8 !== 32'h8) $display("FAIL wrap_adel got %b/%h/%h want 1/0/8", bus.D_exc_adel, bus.D_pc, bus.D_pc8); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset(0);
    tick(0, 0, 1, 32'h3100);
    tick(0, 0, 0, 0);
    n_total++; if (bus.F_pc !== 32'h3104) $display("FAIL arst_pre got %h want 00003104", bus.F_pc); else n_pass++;
    tick(0, 0, 1, 32'h3100);
    reset_n = 1'b0;
    #1;
    n_total++; if (bus.F_pc !== 32'h3000) $display("FAIL arst_pc got %h want 00003000", bus.F_pc); else n_pass++;
    n_total++; if ({bus.D_instr, bus.D_pc, bus.D_pc8, bus.fetch_count} !== 128'h0 || bus.D_valid !== 1'b0 || bus.D_exc_adel !== 1'b0) $display("FAIL arst_d got %h %h %h %0d %b%b want all 0", bus.D_instr, bus.D_pc, bus.D_pc8, bus.fetch_count, bus.D_valid, bus.D_exc_adel); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (bus.F_pc !== 32'h3000 || bus.D_valid !== 1'b0) $display("FAIL arst_hold got %h/%b want 00003000/0", bus.F_pc, bus.D_valid); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    bit s, f, r;
    logic [31:0] n, word;
    bit a;
    int errs;
    errs = 0;
    do_reset(1);
    m_pc = PC_RESET; m_instr = 0; m_dpc = 0; m_dpc8 = 0; m_valid = 0; m_adel = 0; m_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 6) == 0);
      r = ($urandom_range(0, 2) == 0);
      n = ($urandom_range(0, 7) == 0) ? $urandom : IM_BASE + 32'(4 * $urandom_range(0, IM_WORDS - 1));
      a = m_adel_of(m_pc);
      word = a ? 32'h0 : rom[m_index(m_pc)];
      if (f) begin
        m_instr = 0; m_valid = 0; m_adel = 0;
      end else if (!s) begin
        m_instr = word; m_dpc = m_pc; m_dpc8 = m_pc + 8; m_valid = 1; m_adel = a; m_cnt = m_cnt + 1;
      end
      if (!s) m_pc = r ? n : m_pc + 4;
      tick(s, f, r, n);
      n_total++;
      if (bus.F_pc !== m_pc || bus.D_instr !== m_instr || bus.D_pc !== m_dpc || bus.D_pc8 !== m_dpc8 ||
          bus.D_valid !== m_valid || bus.D_exc_adel !== m_adel || bus.fetch_count !== m_cnt) begin
        if (errs < 5) $display("FAIL rand_%0d got pc=%h i=%h dpc=%h v=%b e=%b c=%0d want pc=%h i=%h dpc=%h v=%b e=%b c=%0d",
                               i, bus.F_pc, bus.D_instr, bus.D_pc, bus.D_valid, bus.D_exc_adel, bus.fetch_count,
                               m_pc, m_instr, m_dpc, m_valid, m_adel, m_cnt);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    bus.stall = 0; bus.flush = 0; bus.redirect = 0; bus.npc = 0;
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_flush_and_adel();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
